// File: rtl/lut_load_ctrl.sv
// Ping-pong DDS lookup RAM loader for two channels.
// Avalon-MM writes fill the inactive bank; banks swap at phase wrap.
module lut_load_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic              read_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [1:0]        phase_wrap,
  output logic              ram_we,
  output logic              ram_ch,
  output logic              ram_bank,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [1:0]        bank_sel,
  output logic [5:0]        evt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    FULL    = 2'd2
  } st_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic        wr_q;
  logic        rd_q;
  logic [1:0]  adr_q;
  logic [31:0] wd_q;
  logic [1:0]  wrap_q;

  st_t             st_q   [2];
  st_t             st_d   [2];
  logic [ADDR_W:0] ptr_q  [2];
  logic [ADDR_W:0] ptr_d  [2];
  logic [1:0]      pend_q;
  logic [1:0]      pend_d;
  logic            sel_q;
  logic            sel_d;
  logic [1:0]      bank_d;
  logic [5:0]      evt_d;
  logic [31:0]     rdata_d;
  logic [31:0]     status;
  logic            we_d;
  logic            ch_d;
  logic            bk_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdat_d;

  logic       ctrl_w;
  logic       data_w;
  logic [1:0] start_c;
  logic [1:0] arm_c;
  logic [1:0] dat_c;
  logic [1:0] swap_c;

  // Bus and wrap inputs are registered first; all effects land one edge later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      adr_q  <= '0;
      wd_q   <= '0;
      wrap_q <= '0;
    end else begin
      wr_q   <= chipselect && !write_n;
      rd_q   <= chipselect && !read_n;
      adr_q  <= address;
      wd_q   <= writedata;
      wrap_q <= phase_wrap;
    end
  end

  always_comb begin
    ctrl_w  = wr_q && (adr_q == 2'd0);
    data_w  = wr_q && (adr_q == 2'd1);
    start_c = '0;
    arm_c   = '0;
    dat_c   = '0;
    swap_c  = '0;
    for (int c = 0; c < 2; c++) begin
      start_c[c] = ctrl_w && wd_q[4] && (wd_q[0] == 1'(c));
      arm_c[c]   = ctrl_w && wd_q[8] && (wd_q[0] == 1'(c));
      dat_c[c]   = data_w && (sel_q == 1'(c));
      swap_c[c]  = wrap_q[c] && pend_q[c] && (st_q[c] == FULL)
                   && !start_c[c];
    end
  end

  always_comb begin
    status          = '0;
    status[ADDR_W:0] = ptr_q[sel_q];
    status[17:16]   = st_q[sel_q];
    status[20]      = pend_q[sel_q];
    status[25:24]   = bank_sel;
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      st_d[c]  = st_q[c];
      ptr_d[c] = ptr_q[c];
    end
    pend_d  = pend_q;
    bank_d  = bank_sel;
    evt_d   = evt;
    sel_d   = ctrl_w ? wd_q[0] : sel_q;
    rdata_d = readdata;
    we_d    = 1'b0;
    ch_d    = ram_ch;
    bk_d    = ram_bank;
    addr_d  = ram_addr;
    wdat_d  = ram_wdata;

    if (rd_q) begin
      rdata_d = (adr_q == 2'd2) ? status : 32'd0;
    end

    for (int c = 0; c < 2; c++) begin
      if (dat_c[c]) begin
        if (st_q[c] == LOADING) begin
          we_d     = 1'b1;
          ch_d     = 1'(c);
          bk_d     = ~bank_sel[c];
          addr_d   = ptr_q[c][ADDR_W-1:0];
          wdat_d   = wd_q[DATA_W-1:0];
          ptr_d[c] = ptr_q[c] + 1'b1;
          if (ptr_d[c] == DEPTH) begin
            st_d[c]       = FULL;
            evt_d[3*c]    = ~evt[3*c];
          end
        end else begin
          evt_d[3*c+2] = ~evt[3*c+2];
        end
      end

      unique case (1'b1)
        start_c[c]: begin
          ptr_d[c]  = '0;
          st_d[c]   = LOADING;
          pend_d[c] = 1'b0;
        end
        swap_c[c]: begin
          bank_d[c]    = ~bank_sel[c];
          pend_d[c]    = 1'b0;
          st_d[c]      = IDLE;
          ptr_d[c]     = '0;
          evt_d[3*c+1] = ~evt[3*c+1];
        end
        default: ;
      endcase

      // An arm that meets a wrap is kept for the following wrap.
      if (arm_c[c]) begin
        pend_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        st_q[c]  <= IDLE;
        ptr_q[c] <= '0;
      end
      pend_q    <= '0;
      sel_q     <= 1'b0;
      bank_sel  <= '0;
      evt       <= '0;
      readdata  <= '0;
      ram_we    <= 1'b0;
      ram_ch    <= 1'b0;
      ram_bank  <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        st_q[c]  <= st_d[c];
        ptr_q[c] <= ptr_d[c];
      end
      pend_q    <= pend_d;
      sel_q     <= sel_d;
      bank_sel  <= bank_d;
      evt       <= evt_d;
      readdata  <= rdata_d;
      ram_we    <= we_d;
      ram_ch    <= ch_d;
      ram_bank  <= bk_d;
      ram_addr  <= addr_d;
      ram_wdata <= wdat_d;
    end
  end

endmodule

// File: tb/tb_lut_load_ctrl.sv
// Bench for lut_load_ctrl: transaction-level model plus literal checks.
// Every bus/wrap input takes effect two clock edges after being driven.
module tb_lut_load_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [1:0]  phase_wrap = '0;
  logic        ram_we;
  logic        ram_ch;
  logic        ram_bank;
  logic [9:0]  ram_addr;
  logic [13:0] ram_wdata;
  logic [1:0]  bank_sel;
  logic [5:0]  evt;

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;
  int t5 = 0;
  logic prev5 = 1'b0;

  lut_load_ctrl #(.ADDR_W(10), .DATA_W(14)) dut (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n), .read_n(read_n),
    .writedata(writedata), .readdata(readdata),
    .phase_wrap(phase_wrap), .ram_we(ram_we), .ram_ch(ram_ch),
    .ram_bank(ram_bank), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .bank_sel(bank_sel), .evt(evt)
  );

  always #5 clk = ~clk;

  // Model state: per-channel state 0/1/2, fill count, pending, bank.
  int          m_st [2] = '{0, 0};
  int          m_ptr[2] = '{0, 0};
  bit          m_pend[2] = '{0, 0};
  bit          m_bank[2] = '{0, 0};
  bit          m_sel = 0;
  bit [5:0]    m_evt = '0;
  bit          m_we = 0;
  bit          m_ch = 0;
  bit          m_bk = 0;
  int          m_addr = 0;
  int          m_wd = 0;
  logic [31:0] m_rd = '0;
  bit          d_wr = 0;
  bit          d_rd = 0;
  bit [1:0]    d_a = '0;
  bit [31:0]   d_wd = '0;
  bit [1:0]    d_wrap = '0;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_st[c] = 0; m_ptr[c] = 0; m_pend[c] = 0; m_bank[c] = 0;
    end
    m_sel = 0; m_evt = '0; m_we = 0; m_rd = '0;
    m_ch = 0; m_bk = 0; m_addr = 0; m_wd = 0;
    d_wr = 0; d_rd = 0; d_a = '0; d_wd = '0; d_wrap = '0;
  endtask

  task automatic model_step();
    bit start, arm, data, swap;
    m_we = 0;
    if (d_rd) begin
      if (d_a == 2) begin
        m_rd = 32'(m_ptr[m_sel]) | (32'(m_st[m_sel]) << 16)
             | (32'(m_pend[m_sel]) << 20)
             | (32'(m_bank[0]) << 24) | (32'(m_bank[1]) << 25);
      end else begin
        m_rd = 0;
      end
    end
    for (int c = 0; c < 2; c++) begin
      start = d_wr && d_a == 0 && d_wd[4] && d_wd[0] == c[0];
      arm   = d_wr && d_a == 0 && d_wd[8] && d_wd[0] == c[0];
      data  = d_wr && d_a == 1 && m_sel == c[0];
      swap  = d_wrap[c] && m_pend[c] && m_st[c] == 2 && !start;
      if (data) begin
        if (m_st[c] == 1) begin
          m_we = 1; m_ch = c[0]; m_bk = !m_bank[c];
          m_addr = m_ptr[c]; m_wd = int'(d_wd[13:0]);
          m_ptr[c]++;
          if (m_ptr[c] == 1024) begin
            m_st[c] = 2;
            m_evt[3*c] = !m_evt[3*c];
          end
        end else begin
          m_evt[3*c+2] = !m_evt[3*c+2];
        end
      end
      if (start) begin
        m_ptr[c] = 0; m_st[c] = 1; m_pend[c] = 0;
      end
      if (swap) begin
        m_bank[c] = !m_bank[c]; m_pend[c] = 0;
        m_st[c] = 0; m_ptr[c] = 0;
        m_evt[3*c+1] = !m_evt[3*c+1];
      end
      if (arm) m_pend[c] = 1;
    end
    if (d_wr && d_a == 0) m_sel = d_wd[0];
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        model_reset();
      end else begin
        model_step();
        d_wr = chipselect && !write_n;
        d_rd = chipselect && !read_n;
        d_a = address;
        d_wd = writedata;
        d_wrap = phase_wrap;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("ram_we", 32'(ram_we), 32'(m_we));
      chk("bank_sel", 32'(bank_sel), {30'd0, m_bank[1], m_bank[0]});
      chk("evt", 32'(evt), 32'(m_evt));
      chk("readdata", readdata, m_rd);
      if (m_we) begin
        chk("ram_ch", 32'(ram_ch), 32'(m_ch));
        chk("ram_bank", 32'(ram_bank), 32'(m_bk));
        chk("ram_addr", 32'(ram_addr), 32'(m_addr));
        chk("ram_wdata", 32'(ram_wdata), 32'(m_wd));
      end
      if (ram_we === 1'b1) we_cnt++;
      if (evt[5] !== prev5) t5++;
      prev5 = evt[5];
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d,
                    input logic [1:0] w = 2'b00);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    phase_wrap = w;
    @(posedge clk); #1;
    chipselect = 0; write_n = 1; phase_wrap = 0;
  endtask

  task automatic rd(input logic [1:0] a);
    chipselect = 1; read_n = 0; address = a;
    @(posedge clk); #1;
    chipselect = 0; read_n = 1;
  endtask

  task automatic wrap(input logic [1:0] w);
    phase_wrap = w;
    @(posedge clk); #1;
    phase_wrap = 0;
  endtask

  task automatic load(input int ch, input int n);
    wr(2'd0, 32'h10 | 32'(ch));
    for (int i = 0; i < n; i++) wr(2'd1, 32'(i));
  endtask

  initial begin
    idle(3);
    reset_n = 1;
    idle(1);

    rd(2'd2); idle(3);
    chk("reset_status", readdata, 32'h0);
    chk("reset_evt", 32'(evt), 32'h0);
    chk("reset_bank", 32'(bank_sel), 32'h0);

    wrap(2'b01); idle(3);
    chk("wrap_idle_nop", 32'(bank_sel), 32'h0);

    load(0, 1024); idle(3);
    chk("load0_we_cnt", 32'(we_cnt), 32'd1024);
    chk("load0_evt", 32'(evt), 32'h01);
    rd(2'd2); idle(3);
    chk("load0_status", readdata, 32'h0002_0400);

    wrap(2'b01); idle(3);
    chk("wrap_unarmed", 32'(bank_sel), 32'h0);
    wr(2'd0, 32'h100); idle(2);
    wrap(2'b01); idle(1);
    chk("swap0_bank", 32'(bank_sel), 32'h1);
    chk("swap0_evt", 32'(evt), 32'h03);
    rd(2'd2); idle(3);
    chk("swap0_status", readdata, 32'h0100_0000);

    wr(2'd0, 32'h1);
    wr(2'd1, 32'h7);
    load(1, 1024);
    wr(2'd1, 32'h5); idle(3);
    chk("ovr_toggles", 32'(t5), 32'd2);
    chk("ovr_we_cnt", 32'(we_cnt), 32'd2048);
    chk("ovr_evt", 32'(evt), 32'h0B);

    load(0, 1024);
    wr(2'd0, 32'h100);
    wr(2'd0, 32'h101); idle(2);
    wrap(2'b11); idle(1);
    chk("dual_bank", 32'(bank_sel), 32'h2);
    chk("dual_evt", 32'(evt), 32'h18);

    load(0, 1024);
    wr(2'd0, 32'h100); idle(2);
    wr(2'd0, 32'h10, 2'b01); idle(2);
    rd(2'd2); idle(3);
    chk("start_wins", readdata, 32'h0201_0000);

    load(1, 500);
    reset_n = 0; #1;
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_out", {ram_we, ram_ch, ram_bank, ram_addr, ram_wdata},
        32'h0);
    chk("rst_evt_bank", {24'd0, bank_sel, evt}, 32'h0);
    idle(2);
    reset_n = 1;
    idle(1);
    rd(2'd2); idle(3);
    chk("post_rst_status", readdata, 32'h0);
    wr(2'd0, 32'h1);
    rd(2'd2); idle(3);
    chk("post_rst_ch1", readdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lut_load_ctrl.md
# lut_load_ctrl

Loads DDS waveform samples written by the Nios II into a ping-pong lookup RAM for two channels. It swaps each channel's active bank at that channel's phase wrap. It reports load-done, swap-done and overrun events on a 6-bit toggle-encoded bus that feeds the lookup-RAM interrupt PIO directly. It sits between the Avalon-MM fabric and the LUT RAM write port / DDS read side, all in the `clk` domain.

## Interface
- ADDR_W, 10, LUT depth per bank = 2^ADDR_W samples
- DATA_W, 14, sample width (DAC code)
- clk  in  1  system clock; all ports synchronous to it
- reset_n  in  1  reset, asynchronous, active-low
- address  in  2  Avalon-MM register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- read_n  in  1  active-low read strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- phase_wrap  in  2  one-cycle pulse per channel when its phase accumulator wraps
- ram_we  out  1  LUT RAM write enable
- ram_ch  out  1  target channel of write
- ram_bank  out  1  target bank of write (always the inactive bank)
- ram_addr  out  ADDR_W  write address
- ram_wdata  out  DATA_W  write data
- bank_sel  out  2  active (DDS-read) bank per channel
- evt  out  6  toggle events: [0] ch0 load_done, [1] ch0 swap_done, [2] ch0 overrun, [3..5] same for ch1

## Operation
- A write is `chipselect && !write_n`. A read is `chipselect && !read_n`.
- Register map:
  - 0 CTRL (W): bit0 = selected channel `sel`; bit4 = START; bit8 = ARM_SWAP. START and ARM_SWAP act on the channel in writedata bit0.
  - 1 DATA (W): writedata[DATA_W-1:0] is the sample for channel `sel`.
  - 2 STATUS (R): [ADDR_W:0] ptr of sel; [17:16] state of sel; [20] swap_pending of sel; [25:24] bank_sel; other bits 0.
  - 3 reads 0.
- Per-channel state: IDLE=0, LOADING=1, FULL=2. Each channel also has ptr (ADDR_W+1 bits) and swap_pending.
- START: ptr←0, state←LOADING, swap_pending←0. START is legal in any state; from LOADING it restarts the load.
- DATA write in LOADING: write the sample to the inactive bank (~bank_sel[ch]) at ptr, then ptr←ptr+1.
  - If ptr reaches 2^ADDR_W: state←FULL and toggle load_done.
- DATA write in IDLE or FULL: drop the sample, toggle overrun, no RAM write.
- ARM_SWAP: swap_pending←1 in any state.
- Swap execution: on phase_wrap[ch] with swap_pending && state==FULL:
  - bank_sel[ch] toggles, swap_pending←0, state←IDLE, ptr←0, toggle swap_done.
- phase_wrap without those conditions: no effect; a pending swap stays pending.
- Event encoding: each event flips its evt bit exactly once. The PIO's edge detector then captures exactly one edge per event.
- Channels are fully independent. Both channels may swap in the same cycle.
- Simultaneous events on one channel:
  - START and phase_wrap with pending/FULL in the same cycle: START wins, no swap.
  - ARM_SWAP and phase_wrap in the same cycle: the arm is registered; the swap happens at the next wrap.
  - The CTRL write that changes `sel` takes effect for DATA writes from the next cycle.

## Timing
- Reset (async) clears all outputs to 0 and clears internal state: readdata, ram_*, bank_sel, evt, ptr, swap_pending; state=IDLE.
- DATA write sampled at edge N: ram_we/ram_addr/ram_wdata/ram_bank/ram_ch valid for one cycle after edge N+1.
  - ptr, state and load_done/overrun toggles are also visible after edge N+1.
- Back-to-back DATA writes every cycle are supported; there is no waitrequest.
- phase_wrap sampled at edge N: bank_sel and swap_done toggle after edge N+1. The DDS read side must see the new bank from that cycle.
- Read at edge N: readdata valid after edge N+1. readdata holds its value otherwise.
- Reset asserted mid-load: the partial load is discarded and the bank is not swapped. After release, both channels are IDLE on bank 0.

## Test plan
- Reset, then read STATUS: all 0. evt=0, bank_sel=0, ram_we never asserted.
- Load ch0:
  - Stimulus: START ch0, then 1024 DATA writes of 0..1023.
  - Response: ram_we pulses 1024 times, ram_bank=1, ram_addr=0..1023, ram_wdata=0..1023.
  - evt[0] toggles once, after the last write. STATUS state=2, ptr=1024.
- Swap ch0:
  - Stimulus: ARM_SWAP ch0, then a phase_wrap[0] pulse.
  - Response: bank_sel=01 one cycle after the pulse, evt[1] toggles, STATUS state=0, pending=0.
  - An earlier phase_wrap[0] before ARM_SWAP changes nothing.
- Overrun:
  - Stimulus: DATA write to ch1 in IDLE, then one extra DATA write after ch1 reaches FULL.
  - Response: evt[5] toggles twice total, no ram_we for either write.
- Simultaneous events:
  - Both channels FULL and armed, phase_wrap=11 → bank_sel flips both bits, evt[1] and evt[4] toggle in the same cycle.
  - START ch0 coinciding with phase_wrap[0] → no swap, state=1.
- Reset mid-load:
  - Stimulus: assert reset_n=0 after 500 ch1 samples.
  - Response: all outputs 0 immediately; after release, STATUS ptr=0, state=0.
